// File: rtl/wb2axi.sv
`default_nettype none
// ============================================================================
// Module   : wb2axi
// Purpose  : Wishbone classic (32-bit) slave to single-beat 64-bit AXI-lite
//            master bridge; one outstanding transfer, lane steered by addr[2].
// Revision : 1.0 - initial release
// ============================================================================
module wb2axi #(
    parameter int AW     = 12,
    parameter int IW     = 1,
    parameter int AXI_ID = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    // Wishbone classic slave
    input  logic [AW-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    // AXI write address
    output logic [AW-1:0] o_awaddr,
    output logic [IW-1:0] o_awid,
    output logic          o_awvalid,
    input  logic          i_awready,
    // AXI write data
    output logic [63:0]   o_wdata,
    output logic [7:0]    o_wstrb,
    output logic          o_wvalid,
    input  logic          i_wready,
    // AXI write response
    input  logic [IW-1:0] i_bid,
    input  logic [1:0]    i_bresp,
    input  logic          i_bvalid,
    output logic          o_bready,
    // AXI read address
    output logic [AW-1:0] o_araddr,
    output logic [IW-1:0] o_arid,
    output logic          o_arvalid,
    input  logic          i_arready,
    // AXI read data
    input  logic [63:0]   i_rdata,
    input  logic [IW-1:0] i_rid,
    input  logic [1:0]    i_rresp,
    input  logic          i_rlast,
    input  logic          i_rvalid,
    output logic          o_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] C_ID = IW'(AXI_ID);

    logic [2:0]    r_state;
    logic [2:0]    w_next;

    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_arvalid;
    logic          r_bready;
    logic          r_rready;
    logic          r_ack;
    logic          r_err;
    logic          r_lane;
    logic          r_aborted;
    logic [1:0]    r_resp;
    logic [AW-1:0] r_awaddr;
    logic [AW-1:0] r_araddr;
    logic [63:0]   r_wdata;
    logic [7:0]    r_wstrb;
    logic [31:0]   r_rdt;

    logic          w_req;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_aw_done;
    logic          w_w_done;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_busy;
    logic          w_ack_nxt;
    logic          w_err_nxt;
    logic [AW-1:0] w_addr;
    logic          w_lane;
    logic          w_unused;

    // i_wb_adr is the word address, so its LSB is byte-address bit 2
    assign w_addr   = {i_wb_adr, 2'b00};
    assign w_lane   = i_wb_adr[0];
    assign w_unused = ^{i_bid, i_rid, i_rlast};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = i_wb_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_aw_done && w_w_done) begin
                    w_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (w_b_hs) begin
                    w_next = S_DONE;
                end
            end
            S_READ: begin
                if (w_ar_hs) begin
                    w_next = S_RRESP;
                end
            end
            S_RRESP: begin
                if (w_r_hs) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        // A new request is not taken while the previous ack/err is visible
        w_req     = (r_state == S_IDLE) && i_wb_cyc && i_wb_stb && !r_ack && !r_err;
        w_aw_hs   = (r_state == S_WRITE) && r_awvalid && i_awready;
        w_w_hs    = (r_state == S_WRITE) && r_wvalid && i_wready;
        w_aw_done = !r_awvalid || i_awready;
        w_w_done  = !r_wvalid || i_wready;
        w_b_hs    = (r_state == S_WRESP) && r_bready && i_bvalid;
        w_ar_hs   = (r_state == S_READ) && r_arvalid && i_arready;
        w_r_hs    = (r_state == S_RRESP) && r_rready && i_rvalid;
        w_busy    = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                    (r_state == S_READ)  || (r_state == S_RRESP);
        w_ack_nxt = (r_state == S_DONE) && !r_aborted && !r_resp[1];
        w_err_nxt = (r_state == S_DONE) && !r_aborted && r_resp[1];
    end

    // ------------------------------------------------------------------
    // Datapath and handshake registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_lane    <= 1'b0;
            r_aborted <= 1'b0;
            r_resp    <= 2'b00;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdt     <= '0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_err_nxt;

            if (w_req) begin
                r_lane    <= w_lane;
                r_aborted <= 1'b0;
                if (i_wb_we) begin
                    r_awaddr  <= w_addr;
                    r_wdata   <= {i_wb_dat, i_wb_dat};
                    r_wstrb   <= w_lane ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else begin
                    r_araddr  <= w_addr;
                    r_arvalid <= 1'b1;
                end
            end

            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
            end
            if ((r_state == S_WRITE) && w_aw_done && w_w_done) begin
                r_bready <= 1'b1;
            end
            if (w_b_hs) begin
                r_bready <= 1'b0;
                r_resp   <= i_bresp;
            end

            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end
            if (w_r_hs) begin
                r_rready <= 1'b0;
                r_resp   <= i_rresp;
                if (!r_aborted && i_wb_cyc) begin
                    r_rdt <= r_lane ? i_rdata[63:32] : i_rdata[31:0];
                end
            end

            // The AXI side always runs to completion; only the WB reply is dropped
            if (w_busy && !i_wb_cyc) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign o_wb_rdt  = r_rdt;
    assign o_wb_ack  = r_ack;
    assign o_wb_err  = r_err;
    assign o_awaddr  = r_awaddr;
    assign o_awid    = C_ID;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;
    assign o_araddr  = r_araddr;
    assign o_arid    = C_ID;
    assign o_arvalid = r_arvalid;
    assign o_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_wb2axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb2axi
// Purpose  : Self-checking bench for wb2axi with a cycle-driven AXI slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb2axi;

    localparam int AW = 12;
    localparam int IW = 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-3:0] i_wb_adr = '0;
    logic [31:0]   i_wb_dat = '0;
    logic [3:0]    i_wb_sel = '0;
    logic          i_wb_we = 1'b0;
    logic          i_wb_cyc = 1'b0;
    logic          i_wb_stb = 1'b0;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic          o_wb_err;
    logic [AW-1:0] o_awaddr;
    logic [IW-1:0] o_awid;
    logic          o_awvalid;
    logic          i_awready = 1'b0;
    logic [63:0]   o_wdata;
    logic [7:0]    o_wstrb;
    logic          o_wvalid;
    logic          i_wready = 1'b0;
    logic [IW-1:0] i_bid = '0;
    logic [1:0]    i_bresp = '0;
    logic          i_bvalid = 1'b0;
    logic          o_bready;
    logic [AW-1:0] o_araddr;
    logic [IW-1:0] o_arid;
    logic          o_arvalid;
    logic          i_arready = 1'b0;
    logic [63:0]   i_rdata = '0;
    logic [IW-1:0] i_rid = '0;
    logic [1:0]    i_rresp = '0;
    logic          i_rlast = 1'b1;
    logic          i_rvalid = 1'b0;
    logic          o_rready;

    wb2axi #(.AW(AW), .IW(IW), .AXI_ID(0)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arid(o_arid), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rid(i_rid), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    wstrb;
        logic [31:0]   rdt;
        int            ack;
        int            err;
        int            lat;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    int            obs_ack, obs_err, obs_lat, obs_viol;
    bit            obs_to;
    logic [AW-1:0] obs_awaddr, obs_araddr;
    logic [63:0]   obs_wdata;
    logic [7:0]    obs_wstrb;
    logic [31:0]   obs_rdt;

    logic [134:0] w_allout;
    assign w_allout = {o_wb_rdt, o_wb_ack, o_wb_err, o_awaddr, o_awvalid, o_wdata, o_wstrb,
                       o_wvalid, o_bready, o_araddr, o_arvalid, o_rready};

    // Reference model: what the bridge must produce for one request
    function automatic void push_exp(input bit we, input logic [AW-1:0] badr,
                                     input logic [31:0] dat, input logic [3:0] sel,
                                     input logic [1:0] resp, input logic [63:0] rdata,
                                     input int lat, input bit aborted);
        exp_t e;
        e.addr  = {badr[AW-1:2], 2'b00};
        e.wdata = {dat, dat};
        e.wstrb = badr[2] ? {sel, 4'h0} : {4'h0, sel};
        e.rdt   = badr[2] ? rdata[63:32] : rdata[31:0];
        e.ack   = (!aborted && !resp[1]) ? 1 : 0;
        e.err   = (!aborted && resp[1]) ? 1 : 0;
        e.lat   = lat;
        if (we) e.rdt = 32'h0;
        exp_q.push_back(e);
    endfunction

    // Drives one Wishbone request and plays a zero/variable-wait AXI slave
    task automatic run_xfer(input bit we, input logic [AW-1:0] badr, input logic [31:0] dat,
                            input logic [3:0] sel, input int aw_dly, input int w_dly,
                            input int ar_dly, input int b_dly, input logic [1:0] resp,
                            input logic [63:0] rdata, input int drop_at);
        int n = 0, post = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
        bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
        bit aw_seen = 0, w_seen = 0, ar_seen = 0, prev_bready = 0, prev_rready = 0;
        obs_ack = 0; obs_err = 0; obs_lat = -1; obs_viol = 0; obs_to = 0;
        obs_awaddr = 'x; obs_araddr = 'x; obs_wdata = 'x; obs_wstrb = 'x;
        i_wb_adr = badr[AW-1:2]; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        forever begin
            @(posedge i_clk);
            @(negedge i_clk);
            n++;
            if (i_awready) aw_done = 1;
            if (i_wready) w_done = 1;
            if (i_arready) ar_done = 1;
            if (i_bvalid && prev_bready) b_done = 1;
            if (i_rvalid && prev_rready) r_done = 1;
            if ((aw_done && o_awvalid) || (w_done && o_wvalid) || (ar_done && o_arvalid))
                obs_viol++;
            if (o_wb_ack && o_wb_err) obs_viol++;
            if (o_wb_ack || o_wb_err) begin
                if (obs_lat < 0) obs_lat = n;
                obs_ack += int'(o_wb_ack);
                obs_err += int'(o_wb_err);
            end
            if (o_awvalid && !aw_done) begin
                if (!aw_seen) begin obs_awaddr = o_awaddr; aw_seen = 1; end
                else if (o_awaddr !== obs_awaddr) obs_viol++;
            end
            if (o_wvalid && !w_done) begin
                if (!w_seen) begin obs_wdata = o_wdata; obs_wstrb = o_wstrb; w_seen = 1; end
                else if (o_wdata !== obs_wdata || o_wstrb !== obs_wstrb) obs_viol++;
            end
            if (o_arvalid && !ar_done) begin
                if (!ar_seen) begin obs_araddr = o_araddr; ar_seen = 1; end
                else if (o_araddr !== obs_araddr) obs_viol++;
            end
            i_awready = o_awvalid && !aw_done && (aw_cnt >= aw_dly);
            if (o_awvalid && !aw_done) aw_cnt++;
            i_wready = o_wvalid && !w_done && (w_cnt >= w_dly);
            if (o_wvalid && !w_done) w_cnt++;
            i_arready = o_arvalid && !ar_done && (ar_cnt >= ar_dly);
            if (o_arvalid && !ar_done) ar_cnt++;
            i_bvalid = aw_done && w_done && !b_done && (b_cnt >= b_dly);
            i_bresp = resp;
            if (aw_done && w_done && !b_done) b_cnt++;
            i_rvalid = ar_done && !r_done;
            i_rdata = rdata;
            i_rresp = resp;
            prev_bready = o_bready;
            prev_rready = o_rready;
            if ((obs_lat >= 0 && n > obs_lat) || (drop_at > 0 && n >= drop_at)) begin
                i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
            end
            if (we ? b_done : r_done) post++;
            if (post >= 5) break;
            if (n >= 100) begin obs_to = 1; break; end
        end
        obs_rdt = o_wb_rdt;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0; i_bvalid = 1'b0; i_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_vec++;
        if (w_allout !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", w_allout);
        end
        n_vec++;
        if (o_awid !== 1'b0 || o_arid !== 1'b0) begin
            n_err++; $display("FAIL reset_ids: got aw=%0d ar=%0d want 0", o_awid, o_arid);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_write_basic();
        exp_t e;
        push_exp(1, 12'h040, 32'hA5A5_1234, 4'hF, 2'b00, 64'h0, 4, 0);
        run_xfer(1, 12'h040, 32'hA5A5_1234, 4'hF, 0, 0, 0, 0, 2'b00, 64'h0, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_awaddr !== e.addr) begin n_err++; $display("FAIL wr_awaddr: got %h want %h", obs_awaddr, e.addr); end
        n_vec++;
        if (obs_wdata !== e.wdata) begin n_err++; $display("FAIL wr_wdata: got %h want %h", obs_wdata, e.wdata); end
        n_vec++;
        if (obs_wstrb !== e.wstrb) begin n_err++; $display("FAIL wr_wstrb: got %h want %h", obs_wstrb, e.wstrb); end
        n_vec++;
        if (obs_ack !== e.ack || obs_err !== e.err) begin
            n_err++; $display("FAIL wr_ack: got ack=%0d err=%0d want ack=%0d err=%0d", obs_ack, obs_err, e.ack, e.err);
        end
        n_vec++;
        if (obs_lat !== e.lat) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", obs_lat, e.lat); end
        n_vec++;
        if (obs_viol !== 0 || obs_to) begin n_err++; $display("FAIL wr_protocol: got viol=%0d timeout=%0d want 0", obs_viol, obs_to); end
    endtask

    task automatic test_write_stall();
        exp_t e;
        // wready immediately, awready 3 cycles later: bready at 5, ack at 7
        push_exp(1, 12'h044, 32'hDEAD_BEEF, 4'h3, 2'b00, 64'h0, 7, 0);
        run_xfer(1, 12'h044, 32'hDEAD_BEEF, 4'h3, 3, 0, 0, 0, 2'b00, 64'h0, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_wstrb !== e.wstrb || obs_awaddr !== e.addr) begin
            n_err++; $display("FAIL stall_payload: got strb=%h addr=%h want strb=%h addr=%h", obs_wstrb, obs_awaddr, e.wstrb, e.addr);
        end
        n_vec++;
        if (obs_ack !== e.ack || obs_lat !== e.lat) begin
            n_err++; $display("FAIL stall_ack: got ack=%0d lat=%0d want ack=%0d lat=%0d", obs_ack, obs_lat, e.ack, e.lat);
        end
        n_vec++;
        if (obs_viol !== 0 || obs_to) begin n_err++; $display("FAIL stall_protocol: got viol=%0d timeout=%0d want 0", obs_viol, obs_to); end
    endtask

    task automatic test_read_lanes();
        exp_t e;
        logic [AW-1:0] adrs [2];
        adrs[0] = 12'h04C;
        adrs[1] = 12'h048;
        for (int i = 0; i < 2; i++) begin
            push_exp(0, adrs[i], 32'h0, 4'h0, 2'b00, 64'h1111_2222_3333_4444, 4, 0);
            run_xfer(0, adrs[i], 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444, 0);
            e = exp_q.pop_front();
            n_vec++;
            if (obs_rdt !== e.rdt) begin n_err++; $display("FAIL rd_lane%0d_rdt: got %h want %h", i, obs_rdt, e.rdt); end
            n_vec++;
            if (obs_araddr !== e.addr) begin n_err++; $display("FAIL rd_lane%0d_araddr: got %h want %h", i, obs_araddr, e.addr); end
            n_vec++;
            if (obs_ack !== e.ack || obs_err !== e.err || obs_lat !== e.lat || obs_viol !== 0 || obs_to) begin
                n_err++; $display("FAIL rd_lane%0d_ack: got ack=%0d err=%0d lat=%0d viol=%0d want ack=%0d err=%0d lat=%0d viol=0",
                                  i, obs_ack, obs_err, obs_lat, obs_viol, e.ack, e.err, e.lat);
            end
        end
    endtask

    task automatic test_errors();
        exp_t e;
        push_exp(1, 12'h100, 32'h1234_5678, 4'hF, 2'b10, 64'h0, 4, 0);
        run_xfer(1, 12'h100, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 2'b10, 64'h0, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_err !== e.err || obs_ack !== e.ack || obs_lat !== e.lat) begin
            n_err++; $display("FAIL wr_slverr: got ack=%0d err=%0d lat=%0d want ack=%0d err=%0d lat=%0d", obs_ack, obs_err, obs_lat, e.ack, e.err, e.lat);
        end
        push_exp(0, 12'h104, 32'h0, 4'h0, 2'b11, 64'hCAFE_0000_0000_F00D, 4, 0);
        run_xfer(0, 12'h104, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 64'hCAFE_0000_0000_F00D, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_err !== e.err || obs_ack !== e.ack) begin
            n_err++; $display("FAIL rd_decerr: got ack=%0d err=%0d want ack=%0d err=%0d", obs_ack, obs_err, e.ack, e.err);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        logic [31:0] keep;
        push_exp(0, 12'h010, 32'h0, 4'h0, 2'b00, 64'h7777_6666_5555_4444, 4, 0);
        run_xfer(0, 12'h010, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 64'h7777_6666_5555_4444, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_rdt !== e.rdt) begin n_err++; $display("FAIL abort_pre_rdt: got %h want %h", obs_rdt, e.rdt); end
        keep = e.rdt;
        // cyc drops in cycle 2 while arready is held off for 5 cycles
        push_exp(0, 12'h018, 32'h0, 4'h0, 2'b00, 64'h9999_8888_AAAA_BBBB, 0, 1);
        run_xfer(0, 12'h018, 32'h0, 4'h0, 0, 0, 5, 0, 2'b00, 64'h9999_8888_AAAA_BBBB, 2);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_ack !== e.ack || obs_err !== e.err) begin
            n_err++; $display("FAIL abort_reply: got ack=%0d err=%0d want ack=%0d err=%0d", obs_ack, obs_err, e.ack, e.err);
        end
        n_vec++;
        if (obs_rdt !== keep) begin n_err++; $display("FAIL abort_rdt: got %h want %h", obs_rdt, keep); end
        n_vec++;
        if (obs_araddr !== e.addr || obs_viol !== 0 || obs_to) begin
            n_err++; $display("FAIL abort_axi: got araddr=%h viol=%0d timeout=%0d want araddr=%h viol=0", obs_araddr, obs_viol, obs_to, e.addr);
        end
        push_exp(1, 12'h020, 32'h0BAD_F00D, 4'h5, 2'b01, 64'h0, 4, 0);
        run_xfer(1, 12'h020, 32'h0BAD_F00D, 4'h5, 0, 0, 0, 0, 2'b01, 64'h0, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_ack !== e.ack || obs_lat !== e.lat || obs_wstrb !== e.wstrb) begin
            n_err++; $display("FAIL abort_next: got ack=%0d lat=%0d strb=%h want ack=%0d lat=%0d strb=%h", obs_ack, obs_lat, obs_wstrb, e.ack, e.lat, e.wstrb);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit seen = 0;
        int bad = 0;
        i_wb_adr = 10'h030; i_wb_dat = 32'h5555_AAAA; i_wb_sel = 4'hF; i_wb_we = 1'b1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            i_awready = o_awvalid;
            i_wready  = o_wvalid;
            if (o_bready) seen = 1;
        end
        i_awready = 1'b0; i_wready = 1'b0;
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL rstmid_wresp: got bready=0 want 1 within 20 cycles"); end
        #2 i_rst = 1'b1;
        #1;
        n_vec++;
        if (w_allout !== '0) begin n_err++; $display("FAIL rstmid_async: got %h want 0", w_allout); end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_wb_ack || o_wb_err || o_awvalid || o_wvalid || o_bready || o_arvalid || o_rready) bad++;
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL rstmid_spurious: got %0d active cycles want 0", bad); end
        push_exp(1, 12'h0C0, 32'h0000_00FF, 4'h1, 2'b00, 64'h0, 4, 0);
        run_xfer(1, 12'h0C0, 32'h0000_00FF, 4'h1, 0, 0, 0, 0, 2'b00, 64'h0, 0);
        e = exp_q.pop_front();
        n_vec++;
        if (obs_ack !== e.ack || obs_lat !== e.lat || obs_awaddr !== e.addr) begin
            n_err++; $display("FAIL rstmid_after: got ack=%0d lat=%0d addr=%h want ack=%0d lat=%0d addr=%h", obs_ack, obs_lat, obs_awaddr, e.ack, e.lat, e.addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            bit            we    = 1'($urandom_range(0, 1));
            logic [AW-1:0] badr  = AW'($urandom_range(0, 1023)) << 2;
            logic [31:0]   dat   = $urandom;
            logic [3:0]    sel   = 4'($urandom_range(1, 15));
            logic [1:0]    resp  = 2'($urandom_range(0, 3));
            logic [63:0]   rdata = {$urandom, $urandom};
            push_exp(we, badr, dat, sel, resp, rdata, 0, 0);
            run_xfer(we, badr, dat, sel, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2), resp, rdata, 0);
            e = exp_q.pop_front();
            n_vec++;
            if (obs_ack !== e.ack || obs_err !== e.err || obs_viol !== 0 || obs_to ||
                (we ? (obs_awaddr !== e.addr || obs_wdata !== e.wdata || obs_wstrb !== e.wstrb)
                    : (obs_araddr !== e.addr || obs_rdt !== e.rdt))) begin
                n_err++;
                $display("FAIL b2b_%0d we=%0d: got ack=%0d err=%0d addr=%h/%h wd=%h st=%h rdt=%h viol=%0d want ack=%0d err=%0d addr=%h wd=%h st=%h rdt=%h",
                         i, we, obs_ack, obs_err, obs_awaddr, obs_araddr, obs_wdata, obs_wstrb, obs_rdt, obs_viol,
                         e.ack, e.err, e.addr, e.wdata, e.wstrb, e.rdt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_stall();
        test_read_lanes();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
